// File: rtl/display_scan.sv
// rtl/display_scan.sv - time-multiplexed 7-segment digit scanner
// Shadowed value with frame-aligned update, leading-zero blanking and frame strobe.
module display_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int AN_ACTIVE   = 0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEnable,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic                  iBlankLZ,
  output logic [3:0]            oDigit,
  output logic [DIGITS-1:0]     oAnode,
  output logic [2:0]            oIdx,
  output logic                  oFrame
);

  localparam int                CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE != 0) ? '0 : '1;

  typedef enum logic {ST_DARK, ST_SCAN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [4*DIGITS-1:0]   r_stage;
  logic                  r_pending;
  logic [3:0]            r_digit;
  logic [DIGITS-1:0]     r_anode;
  logic                  r_frame;

  logic                  w_tick;
  logic                  w_tc;
  logic                  w_wrap;
  logic [CW-1:0]         w_cnt_nxt;
  logic [2:0]            w_idx_nxt;
  logic [4*DIGITS-1:0]   w_shadow_nxt;
  logic [4*DIGITS-1:0]   w_stage_nxt;
  logic                  w_pending_nxt;
  logic [3:0]            w_digit;
  logic                  w_nz;
  logic                  w_blank;
  logic [DIGITS-1:0]     w_onehot;
  logic [DIGITS-1:0]     w_anode;

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= ST_DARK;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DARK: if (iEnable)  w_state_nxt = ST_SCAN;
      ST_SCAN: if (!iEnable) w_state_nxt = ST_DARK;
      default: w_state_nxt = ST_DARK;
    endcase
  end

  // The counter only advances on edges that both start and end in SCAN, so a
  // dark interval freezes the slot exactly where it was.
  always_comb begin
    w_tick    = (r_state == ST_SCAN) && iEnable;
    w_tc      = w_tick && (r_cnt == CNT_LAST);
    w_wrap    = w_tc && (r_idx == IDX_LAST);
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    if (w_tc) begin
      w_cnt_nxt = '0;
      w_idx_nxt = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end else if (w_tick) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_shadow_nxt  = r_shadow;
    w_stage_nxt   = r_stage;
    w_pending_nxt = r_pending;
    if (r_state == ST_DARK) begin
      if (iLoad) begin
        w_shadow_nxt  = iValue;
        w_pending_nxt = 1'b0;
      end
    end else if (w_wrap) begin
      if (iLoad)          w_shadow_nxt = iValue;
      else if (r_pending) w_shadow_nxt = r_stage;
      w_pending_nxt = 1'b0;
    end else if (iLoad) begin
      w_stage_nxt   = iValue;
      w_pending_nxt = 1'b1;
    end
  end

  // Walk from the top digit down so w_nz covers digits k..DIGITS-1 at slot k.
  always_comb begin
    w_digit = '0;
    w_nz    = 1'b0;
    w_blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_nz = w_nz | (|w_shadow_nxt[4*k +: 4]);
      if (3'(k) == w_idx_nxt) begin
        w_digit = w_shadow_nxt[4*k +: 4];
        w_blank = iBlankLZ && (k != 0) && !w_nz;
      end
    end
    w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt;
    if ((w_state_nxt == ST_SCAN) && !w_blank)
      w_anode = (AN_ACTIVE != 0) ? w_onehot : ~w_onehot;
    else
      w_anode = AN_OFF;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_stage   <= '0;
      r_pending <= 1'b0;
      r_digit   <= '0;
      r_anode   <= AN_OFF;
      r_frame   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      r_stage   <= w_stage_nxt;
      r_pending <= w_pending_nxt;
      r_digit   <= w_digit;
      r_anode   <= w_anode;
      r_frame   <= w_wrap;
    end
  end

  assign oDigit = r_digit;
  assign oAnode = r_anode;
  assign oIdx   = r_idx;
  assign oFrame = r_frame;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - directed self-checking bench for display_scan
// DIGITS=8, REFRESH_DIV=4, active-low anodes.
module tb_display_scan;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEnable;
  logic        iLoad;
  logic [31:0] iValue;
  logic        iBlankLZ;
  logic [3:0]  oDigit;
  logic [7:0]  oAnode;
  logic [2:0]  oIdx;
  logic        oFrame;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;

  display_scan #(.DIGITS(8), .REFRESH_DIV(4), .AN_ACTIVE(0)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iEnable  (iEnable),
    .iLoad    (iLoad),
    .iValue   (iValue),
    .iBlankLZ (iBlankLZ),
    .oDigit   (oDigit),
    .oAnode   (oAnode),
    .oIdx     (oIdx),
    .oFrame   (oFrame)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (ph=%0d)", tag, got, exp, ph);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] idx, input logic [7:0] an,
                           input logic [3:0] dig, input logic frm);
    check({tag, ".idx"},   32'(oIdx),   32'(idx));
    check({tag, ".anode"}, 32'(oAnode), 32'(an));
    check({tag, ".digit"}, 32'(oDigit), 32'(dig));
    check({tag, ".frame"}, 32'(oFrame), 32'(frm));
  endtask

  // One scanning edge; shown is the value the display must be presenting now.
  task automatic scan_tick(input logic [31:0] shown);
    int          k;
    logic [31:0] upper;
    logic        blank;
    logic [7:0]  an;
    tick();
    ph    = (ph + 1) % 32;
    k     = ph / 4;
    upper = shown >> (4 * k);
    blank = iBlankLZ && (k != 0) && (upper == 32'd0);
    an    = blank ? 8'hFF : ~(8'h01 << k);
    check_out("scan", 3'(k), an, upper[3:0], ph == 0);
  endtask

  initial begin
    iRst = 1'b1; iEnable = 1'b1; iLoad = 1'b1; iValue = 32'hDEADBEEF; iBlankLZ = 1'b0;
    repeat (3) begin
      tick();
      check_out("reset", 3'd0, 8'hFF, 4'd0, 1'b0);
    end
    iRst = 1'b0; iEnable = 1'b0; iLoad = 1'b0;
    tick();
    check_out("post_reset", 3'd0, 8'hFF, 4'd0, 1'b0);

    iLoad = 1'b1; iValue = 32'h76543210;
    tick();
    iLoad = 1'b0;
    check_out("dark_load", 3'd0, 8'hFF, 4'd0, 1'b0);

    iEnable = 1'b1;
    tick();
    ph = 0;
    check_out("enable", 3'd0, 8'hFE, 4'd0, 1'b0);
    repeat (32) scan_tick(32'h76543210);

    repeat (12) scan_tick(32'h76543210);
    iLoad = 1'b1; iValue = 32'h99999999;
    scan_tick(32'h76543210);
    iLoad = 1'b0;
    while (ph != 31) scan_tick(32'h76543210);
    repeat (32) scan_tick(32'h99999999);

    iLoad = 1'b1; iValue = 32'h00000420; iBlankLZ = 1'b1;
    scan_tick(32'h00000420);
    iLoad = 1'b0;
    repeat (31) scan_tick(32'h00000420);

    iLoad = 1'b1; iValue = 32'h00000000;
    scan_tick(32'h00000000);
    iLoad = 1'b0;
    repeat (31) scan_tick(32'h00000000);

    iBlankLZ = 1'b0;
    repeat (5) scan_tick(32'h00000000);
    iLoad = 1'b1; iValue = 32'h11111111;
    scan_tick(32'h00000000);
    iLoad = 1'b0;
    repeat (3) scan_tick(32'h00000000);
    iLoad = 1'b1; iValue = 32'h0000ABCD;
    scan_tick(32'h00000000);
    iLoad = 1'b0;
    while (ph != 31) scan_tick(32'h00000000);
    repeat (23) scan_tick(32'h0000ABCD);

    iEnable = 1'b0;
    tick();
    check_out("dark1", 3'd5, 8'hFF, 4'd0, 1'b0);
    tick();
    check_out("dark2", 3'd5, 8'hFF, 4'd0, 1'b0);
    iEnable = 1'b1;
    tick();
    check_out("resume1", 3'd5, 8'hDF, 4'd0, 1'b0);
    tick();
    check_out("resume2", 3'd5, 8'hDF, 4'd0, 1'b0);
    tick();
    check_out("resume3", 3'd6, 8'hBF, 4'd0, 1'b0);
    ph = 24;
    repeat (3) scan_tick(32'h0000ABCD);

    iRst = 1'b1;
    tick();
    check_out("mid_reset", 3'd0, 8'hFF, 4'd0, 1'b0);
    iRst = 1'b0;
    tick();
    check_out("after_reset", 3'd0, 8'hFE, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
